udp_rx_stream_arbiter: RTL and testbench

//  Round-robin scheduler that shares one downstream system-clock consumer between N UDP Rx stream buffers.

---
 rtl/udp_rx_arb_pkg.sv | 38 +++
 rtl/udp_rx_rr_pick.sv | 21 ++
 rtl/udp_rx_stream_arbiter.sv | 177 +++++++++++++++++
 tb/tb_udp_rx_stream_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_rx_arb_pkg.sv
// Shared types and helpers for the UDP Rx stream arbiter.
// Holds the FSM state type, the source-ID width helper and the round-robin scan function.
package udp_rx_arb_pkg;

    typedef enum logic {ARB, XFER} arb_state_t;

    // Upper bound on the arbitrated stream count; sizes the generic scan helper.
    localparam int unsigned MAX_STREAMS = 16;
    localparam int unsigned MAX_ID_W    = 4;

    // Width of a source ID for n streams (never below one bit).
    function automatic int unsigned src_id_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin scan: first set bit of req after 'last', wrapping mod n.
    // Returns {found, index}.
    function automatic logic [MAX_ID_W:0] rr_next(input logic [MAX_STREAMS-1:0] req,
                                                  input logic [MAX_ID_W-1:0]    last,
                                                  input int unsigned            n);
        logic                found;
        logic [MAX_ID_W-1:0] idx;
        int unsigned         k;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= MAX_STREAMS; i++) begin
            if (i <= n) begin
                k = (32'(last) + i) % n;
                if (!found && (|(req & (MAX_STREAMS'(1) << k)))) begin
                    found = 1'b1;
                    idx   = MAX_ID_W'(k);
                end
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/udp_rx_rr_pick.sv
// Combinational round-robin priority pick: request vector and last grant in,
// found flag and granted index out.
module udp_rx_rr_pick
    import udp_rx_arb_pkg::*;
#(
    parameter int unsigned N_STREAMS = 4,
    parameter int unsigned ID_W      = 2
) (
    input  logic [N_STREAMS-1:0] req,
    input  logic [ID_W-1:0]      last,
    output logic                 found,
    output logic [ID_W-1:0]      idx
);

    logic [MAX_ID_W:0] pick;

    assign pick  = rr_next(MAX_STREAMS'(req), MAX_ID_W'(last), N_STREAMS);
    assign found = pick[MAX_ID_W];
    assign idx   = ID_W'(pick[MAX_ID_W-1:0]);

endmodule

// File: rtl/udp_rx_stream_arbiter.sv
// Round-robin scheduler sharing one system-clock consumer between N FWFT stream buffers.
// Grants one stream per bounded burst, pops it, and tags each word with source ID and
// start-of-burst. Optional parity check enabled by defining UDP_RX_ARB_PARITY_CHK_EN.
module udp_rx_stream_arbiter
    import udp_rx_arb_pkg::*;
#(
    parameter int unsigned N_STREAMS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 64,
    localparam int unsigned SRC_ID_W  = src_id_w(N_STREAMS)
) (
    input  logic                            i_sys_clk,
    input  logic                            i_sys_rst,
    input  logic [N_STREAMS-1:0]            i_strm_data_vld,
    input  logic [N_STREAMS*DATA_WIDTH-1:0] i_strm_data,
    input  logic [N_STREAMS-1:0]            i_strm_parity,
    output logic [N_STREAMS-1:0]            o_strm_rd,
    input  logic                            i_out_ready,
    output logic                            o_out_vld,
    output logic [DATA_WIDTH-1:0]           o_out_data,
    output logic                            o_out_parity,
    output logic [SRC_ID_W-1:0]             o_out_src_id,
    output logic                            o_out_sob,
    output logic                            o_parity_err
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t            state_q, state_d;
    logic [SRC_ID_W-1:0]   grant_q, grant_d;     // current grant, doubles as last grant
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic                  first_q, first_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_par_q, out_par_d;
    logic [SRC_ID_W-1:0]   out_src_q, out_src_d;
    logic                  out_sob_q, out_sob_d;

    logic                  pick_found;
    logic [SRC_ID_W-1:0]   pick_idx;
    logic                  sel_vld, sel_par;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  pop, drop;

    udp_rx_rr_pick #(
        .N_STREAMS(N_STREAMS),
        .ID_W     (SRC_ID_W)
    ) u_pick (
        .req  (i_strm_data_vld),
        .last (grant_q),
        .found(pick_found),
        .idx  (pick_idx)
    );

    // Select the granted stream's FWFT head.
    always_comb begin
        sel_vld  = 1'b0;
        sel_par  = 1'b0;
        sel_data = '0;
        for (int unsigned k = 0; k < N_STREAMS; k++) begin
            if (grant_q == SRC_ID_W'(k)) begin
                sel_vld  = i_strm_data_vld[k];
                sel_par  = i_strm_parity[k];
                sel_data = i_strm_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Pop only a non-empty granted stream, and only when the output slot frees up.
    assign pop       = (state_q == XFER) && sel_vld && (!out_vld_q || i_out_ready);
    assign o_strm_rd = pop ? (N_STREAMS'(1) << grant_q) : '0;

`ifdef UDP_RX_ARB_PARITY_CHK_EN
    assign drop = pop && ((^sel_data) ^ sel_par);
`else
    assign drop = 1'b0;
`endif

    // Arbitration FSM and burst accounting.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        first_d     = first_q;
        unique case (state_q)
            ARB: begin
                if (pick_found) begin
                    state_d     = XFER;
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    first_d     = 1'b1;
                end
            end
            XFER: begin
                if (pop) begin
                    first_d     = 1'b0;
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    if (burst_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = ARB;
                    end
                end else if (!sel_vld) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Output register: load on pop (unless dropped), clear once consumed, hold otherwise.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_par_d  = out_par_q;
        out_src_d  = out_src_q;
        out_sob_d  = out_sob_q;
        if (pop) begin
            out_vld_d = !drop;
            if (!drop) begin
                out_data_d = sel_data;
                out_par_d  = sel_par;
                out_src_d  = grant_q;
                out_sob_d  = first_q;
            end
        end else if (i_out_ready) begin
            out_vld_d = 1'b0;
        end
    end

    // State registers with asynchronous clear; reset abandons any partial burst.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q     <= ARB;
            grant_q     <= SRC_ID_W'(N_STREAMS - 1);
            burst_cnt_q <= '0;
            first_q     <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_par_q   <= 1'b0;
            out_src_q   <= '0;
            out_sob_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            first_q     <= first_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_par_q   <= out_par_d;
            out_src_q   <= out_src_d;
            out_sob_q   <= out_sob_d;
        end
    end

`ifdef UDP_RX_ARB_PARITY_CHK_EN
    logic perr_q;

    // One-cycle error pulse following a dropped word.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= drop;
        end
    end

    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_out_vld    = out_vld_q;
    assign o_out_data   = out_data_q;
    assign o_out_parity = out_par_q;
    assign o_out_src_id = out_src_q;
    assign o_out_sob    = out_sob_q;

endmodule

// File: tb/tb_udp_rx_stream_arbiter.sv
// Directed bench for udp_rx_stream_arbiter (N_STREAMS=4, DATA_WIDTH=32, BURST_LEN=4).
// Streams are modelled as FWFT buffers holding a count of known words.
module tb_udp_rx_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  vld;
    logic [N*DW-1:0] data;
    logic [N-1:0]  par;
    logic [N-1:0]  rd;
    logic          ready;
    logic          out_vld;
    logic [DW-1:0] out_data;
    logic          out_par;
    logic [1:0]    src;
    logic          sob;
    logic          perr;

    int errors = 0;
    int checks = 0;
    int rem[N];
    int cnt[N];
    int bad_j;
    int got;

    typedef struct {
        logic        ready;
        logic [3:0]  exp_rd;
        logic        exp_vld;
        logic [1:0]  exp_src;
        logic        exp_sob;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[11];

    udp_rx_stream_arbiter #(
        .N_STREAMS (N),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .i_sys_clk      (clk),
        .i_sys_rst      (rst),
        .i_strm_data_vld(vld),
        .i_strm_data    (data),
        .i_strm_parity  (par),
        .o_strm_rd      (rd),
        .i_out_ready    (ready),
        .o_out_vld      (out_vld),
        .o_out_data     (out_data),
        .o_out_parity   (out_par),
        .o_out_src_id   (src),
        .o_out_sob      (sob),
        .o_parity_err   (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wdata(input int k, input int j);
        if (k == 0 && j == bad_j) return 32'hDEAD_BEEF;
        return 32'hA000_0000 | (32'(k) << 8) | 32'(j);
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            logic [31:0] w;
            w = wdata(k, cnt[k]);
            vld[k] = (rem[k] > 0);
            data[k*DW +: DW] = w;
            par[k] = (^w) ^ (k == 0 && cnt[k] == bad_j);
        end
    endtask

    task automatic sample();
        drive();
        #1;
    endtask

    task automatic advance();
        logic [N-1:0] r;
        r = rd;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            if (r[k]) begin
                rem[k] = rem[k] - 1;
                cnt[k] = cnt[k] + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic start();
        rst = 1'b1;
        ready = 1'b1;
        bad_j = -1;
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            cnt[k] = 0;
        end
        drive();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // c0 ARB, pops at c1..c3 (stream 0), drain, ARB c5, pops c6..c8 (stream 2)
        tbl[0]  = '{1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 32'hA000_0000};
        tbl[3]  = '{1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 32'hA000_0001};
        tbl[4]  = '{1'b1, 4'h0, 1'b1, 2'd0, 1'b0, 32'hA000_0002};
        tbl[5]  = '{1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 32'hA000_0200};
        tbl[8]  = '{1'b1, 4'h4, 1'b1, 2'd2, 1'b0, 32'hA000_0201};
        tbl[9]  = '{1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 32'hA000_0202};
        tbl[10] = '{1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 32'h0};

        rst = 1'b1;
        ready = 1'b1;
        bad_j = -1;
        for (int k = 0; k < N; k++) begin
            rem[k] = 0;
            cnt[k] = 0;
        end
        drive();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_vld", 32'(out_vld), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_par", 32'(out_par), 32'h0);
        chk("rst_src", 32'(src), 32'h0);
        chk("rst_sob", 32'(sob), 32'h0);
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_rd", 32'(rd), 32'h0);

        // Streams 0 and 2, three words each
        start();
        rem[0] = 3;
        rem[2] = 3;
        for (int i = 0; i < 11; i++) begin
            ready = tbl[i].ready;
            sample();
            chk($sformatf("s1_rd[%0d]", i), 32'(rd), 32'(tbl[i].exp_rd));
            chk($sformatf("s1_vld[%0d]", i), 32'(out_vld), 32'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) begin
                chk($sformatf("s1_src[%0d]", i), 32'(src), 32'(tbl[i].exp_src));
                chk($sformatf("s1_sob[%0d]", i), 32'(sob), 32'(tbl[i].exp_sob));
                chk($sformatf("s1_data[%0d]", i), out_data, tbl[i].exp_data);
            end
            advance();
        end

        // All streams always valid: ARB gap then BL pops per grant, order 0,1,2,3,0
        start();
        for (int k = 0; k < N; k++) rem[k] = 100;
        for (int c = 0; c < 25; c++) begin
            int g, p, og, oi;
            logic [3:0] erd;
            logic ev;
            g = (c / 5) % 4;
            p = c % 5;
            erd = (p == 0) ? 4'h0 : (4'h1 << g);
            ev = (p >= 2) || (p == 0 && c >= 5);
            if (p == 0) begin
                og = ((c - 1) / 5) % 4;
                oi = ((c - 1) / 20) * 4 + 3;
            end else begin
                og = g;
                oi = (c / 20) * 4 + (p - 2);
            end
            sample();
            chk($sformatf("s2_rd[%0d]", c), 32'(rd), 32'(erd));
            chk($sformatf("s2_vld[%0d]", c), 32'(out_vld), 32'(ev));
            if (ev) begin
                chk($sformatf("s2_src[%0d]", c), 32'(src), 32'(og));
                chk($sformatf("s2_sob[%0d]", c), 32'(sob), 32'(p == 2));
                chk($sformatf("s2_data[%0d]", c), out_data, wdata(og, oi));
            end
            advance();
        end

        // Stream 1 only, ready toggling: in-order, lossless, no pop while held
        start();
        rem[1] = 6;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            ready = (c % 2 == 0);
            sample();
            if (out_vld && !ready) chk($sformatf("s3_rd_held[%0d]", c), 32'(rd[1]), 32'h0);
            if (out_vld && ready) begin
                chk($sformatf("s3_word[%0d]", got), out_data, wdata(1, got));
                got++;
            end
            advance();
        end
        ready = 1'b1;
        chk("s3_count", 32'(got), 32'd6);

        // Stream 3 empties after 2 words, then refills and is regranted with sob
        start();
        rem[3] = 2;
        sample(); chk("s4_rd0", 32'(rd), 32'h0); advance();
        sample(); chk("s4_rd1", 32'(rd), 32'h8); advance();
        sample(); chk("s4_rd2", 32'(rd), 32'h8); advance();
        sample();
        chk("s4_rd3", 32'(rd), 32'h0);
        chk("s4_data3", out_data, wdata(3, 1));
        advance();
        sample();
        chk("s4_rd4", 32'(rd), 32'h0);
        chk("s4_vld4", 32'(out_vld), 32'h0);
        advance();
        rem[3] = 2;
        sample(); chk("s4_rd5", 32'(rd), 32'h0); advance();
        sample(); chk("s4_rd6", 32'(rd), 32'h8); advance();
        sample();
        chk("s4_vld7", 32'(out_vld), 32'h1);
        chk("s4_sob7", 32'(sob), 32'h1);
        chk("s4_src7", 32'(src), 32'd3);
        chk("s4_data7", out_data, wdata(3, 2));
        advance();

        // Async reset mid-burst
        start();
        for (int k = 0; k < N; k++) rem[k] = 10;
        for (int c = 0; c < 3; c++) begin
            sample();
            advance();
        end
        chk("s5_pre_vld", 32'(out_vld), 32'h1);
        rst = 1'b1;
        #1;
        chk("s5_rst_vld", 32'(out_vld), 32'h0);
        chk("s5_rst_data", out_data, 32'h0);
        chk("s5_rst_sob", 32'(sob), 32'h0);
        chk("s5_rst_rd", 32'(rd), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample(); chk("s5_arb_rd", 32'(rd), 32'h0); advance();
        sample(); chk("s5_regrant_rd", 32'(rd), 32'h1); advance();
        sample();
        chk("s5_sob", 32'(sob), 32'h1);
        chk("s5_data", out_data, wdata(0, 2));
        advance();

        // Bad-parity word on stream 0 followed by a good one
        start();
        rem[0] = 2;
        bad_j = 0;
        sample(); advance();
        sample(); chk("s6_rd1", 32'(rd), 32'h1); advance();
        sample();
        chk("s6_rd2", 32'(rd), 32'h1);
`ifdef UDP_RX_ARB_PARITY_CHK_EN
        chk("s6_drop_vld", 32'(out_vld), 32'h0);
        chk("s6_perr", 32'(perr), 32'h1);
`else
        chk("s6_pass_vld", 32'(out_vld), 32'h1);
        chk("s6_pass_data", out_data, 32'hDEAD_BEEF);
        chk("s6_pass_par", 32'(out_par), 32'h1);
        chk("s6_perr", 32'(perr), 32'h0);
`endif
        advance();
        sample();
        chk("s6_next_vld", 32'(out_vld), 32'h1);
        chk("s6_next_data", out_data, wdata(0, 1));
        chk("s6_next_sob", 32'(sob), 32'h0);
        chk("s6_perr_end", 32'(perr), 32'h0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
